adder_4: RTL and testbench

4-bit carry-lookahead adder with registered outputs. Adds two 4-bit operands and a carry-in using a lookahead carry network; the carry network has no ripple chain. Exposes the per-bit propagate/generate vectors so a higher-level lookahead unit can build wider adders (16/64-bit) from this block.

---
 rtl/adder_pkg.sv | 4 +
 rtl/cla_4.sv | 40 ++++
 rtl/adder_4.sv | 58 +++++
 tb/tb_adder_4.sv | 114 +++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the 4-bit lookahead adder slice.
package adder_pkg;
  localparam int ADDER_W = 4;
endpackage

// File: rtl/cla_4.sv
// Combinational 4-bit carry-lookahead core: every carry is a flat sum of
// products of g, p and cin, so no carry depends on a lower carry signal.
module cla_4
  import adder_pkg::*;
(
  input  logic [ADDER_W-1:0] a,
  input  logic [ADDER_W-1:0] b,
  input  logic               cin,
  output logic [ADDER_W-1:0] sum,
  output logic               cout,
  output logic [ADDER_W-1:0] p,
  output logic [ADDER_W-1:0] g
);

  logic [ADDER_W:0] cy;

  // XOR propagate doubles as the half-sum term.
  assign p = a ^ b;
  assign g = a & b;

  assign cy[0] = cin;
  assign cy[1] = g[0]
               | (p[0] & cin);
  assign cy[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & cin);
  assign cy[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
  assign cy[4] = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ cy[ADDER_W-1:0];
  assign cout = cy[ADDER_W];

endmodule

// File: rtl/adder_4.sv
// 4-bit lookahead adder with every output registered; p/g are exported so a
// higher-level lookahead unit can chain several of these into wider adders.
module adder_4
  import adder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDER_W-1:0] a,
  input  logic [ADDER_W-1:0] b,
  input  logic               cin,
  output logic [ADDER_W-1:0] c,
  output logic               cout,
  output logic [ADDER_W-1:0] p,
  output logic [ADDER_W-1:0] g
);

  logic [ADDER_W-1:0] sum_w;
  logic               cout_w;
  logic [ADDER_W-1:0] p_w;
  logic [ADDER_W-1:0] g_w;

  logic [ADDER_W-1:0] c_p0;
  logic               cout_p0;
  logic [ADDER_W-1:0] p_p0;
  logic [ADDER_W-1:0] g_p0;

  cla_4 u_cla (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum_w),
    .cout (cout_w),
    .p    (p_w),
    .g    (g_w)
  );

  // Stage p0: capture every edge; reset clears the data outputs too, since
  // downstream logic reads them without a qualifying valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_p0    <= '0;
      cout_p0 <= 1'b0;
      p_p0    <= '0;
      g_p0    <= '0;
    end else begin
      c_p0    <= sum_w;
      cout_p0 <= cout_w;
      p_p0    <= p_w;
      g_p0    <= g_w;
    end
  end

  assign c    = c_p0;
  assign cout = cout_p0;
  assign p    = p_p0;
  assign g    = g_p0;

endmodule

// File: tb/tb_adder_4.sv
// Directed and exhaustive checks of adder_4 against bench-computed values.
module tb_adder_4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] c;
  logic       cout;
  logic [3:0] p;
  logic [3:0] g;

  int n_cmp;
  int n_err;

  adder_4 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .c    (c),
    .cout (cout),
    .p    (p),
    .g    (g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] esum,
                         input logic [3:0] ep, input logic [3:0] eg);
    chk({tag, ".sum"}, {cout, c}, esum);
    chk({tag, ".p"}, {1'b0, p}, {1'b0, ep});
    chk({tag, ".g"}, {1'b0, g}, {1'b0, eg});
  endtask

  initial begin
    logic [4:0] esum;
    n_cmp = 0;
    n_err = 0;

    // Reset held two cycles with all-ones inputs.
    rst = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b1;
    tick();
    chk_all("rst1", 5'd0, 4'h0, 4'h0);
    tick();
    chk_all("rst2", 5'd0, 4'h0, 4'h0);

    rst = 1'b0; a = 4'd5; b = 4'd3; cin = 1'b0;
    tick();
    chk_all("5+3", 5'd8, 4'b0110, 4'b0001);

    // Outputs must not follow inputs between edges.
    a = 4'd15; b = 4'd3; cin = 1'b0;
    #2;
    chk("hold", {cout, c}, 5'd8);
    tick();
    chk_all("15+3", 5'd18, 4'b1100, 4'b0011);

    a = 4'd5; b = 4'd13; cin = 1'b0;
    tick();
    chk_all("5+13", 5'd18, 4'b1000, 4'b0101);

    a = 4'd15; b = 4'd0; cin = 1'b1;
    tick();
    chk_all("15+0+1", 5'd16, 4'b1111, 4'b0000);

    cin = 1'b0;
    tick();
    chk_all("15+0+0", 5'd15, 4'b1111, 4'b0000);

    // Exhaustive sweep, one vector per cycle, with a reset pulse in the middle.
    for (int i = 0; i < 512; i++) begin
      if (i == 256) begin
        rst = 1'b1; a = 4'hA; b = 4'h7; cin = 1'b1;
        tick();
        chk_all("sweep_rst", 5'd0, 4'h0, 4'h0);
        rst = 1'b0;
      end
      cin = i[8];
      a   = i[7:4];
      b   = i[3:0];
      esum = 5'(a) + 5'(b) + 5'(cin);
      tick();
      chk_all($sformatf("sweep%0d", i), esum, a ^ b, a & b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
